// File: rtl/stream_denormalizer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : stream_denormalizer                                        |
// | Splits a dense length-framed byte stream into one realigned packet  |
// | per frame.                                                           |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module stream_denormalizer #(
    parameter int DATA_BYTES      = 64,
    parameter int MAX_FRAME_BYTES = 65536
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [8*DATA_BYTES-1:0] i_tdata,
    input  logic [DATA_BYTES-1:0]   i_tkeep,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    output logic [8*DATA_BYTES-1:0] o_tdata,
    output logic [DATA_BYTES-1:0]   o_tkeep,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [31:0]             o_frames,
    output logic                    o_err_trunc,
    output logic                    o_err_len
);

    localparam int                c_FW   = $clog2(2*DATA_BYTES) + 1;
    localparam int                c_OW   = 8*DATA_BYTES;
    localparam int                c_BW   = 16*DATA_BYTES;
    localparam logic [c_FW-1:0]   c_DB   = c_FW'(DATA_BYTES);
    localparam logic [31:0]       c_DB32 = 32'(DATA_BYTES);
    localparam logic [31:0]       c_MAX  = 32'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_SKIP    = 2'd2
    } state_t;

    state_t            r_state, w_state_n;
    logic [c_BW-1:0]   r_buf, w_buf_n;
    logic [c_FW-1:0]   r_fill, w_fill_n;
    logic [31:0]       r_rem, w_rem_n;
    logic              r_eos, w_eos_n;
    logic              r_rdy;

    logic              w_fire;
    logic [c_FW-1:0]   w_in_cnt, w_app;
    logic [c_OW-1:0]   w_in_bmask, w_in_data;
    logic [c_FW-1:0]   w_n, w_skip_n, w_cons, w_load_n, w_ins_pos;
    logic [31:0]       w_hdr_len;
    logic              w_out_free, w_load, w_load_last;
    logic              w_frame_inc, w_trunc, w_lenerr, w_clean;
    logic [DATA_BYTES-1:0] w_load_keep;
    logic [c_OW-1:0]   w_load_bmask;

    assign i_tready   = r_rdy && !areset;
    assign w_fire     = i_tvalid && r_rdy;
    assign w_out_free = !o_tvalid || o_tready;
    assign w_hdr_len  = r_buf[31:0];

    generate
        for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_byte_mask
            assign w_in_bmask[gi*8 +: 8]   = {8{i_tkeep[gi]}};
            assign w_load_bmask[gi*8 +: 8] = {8{w_load_keep[gi]}};
        end
    endgenerate

    always_comb begin
        w_in_cnt = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_in_cnt = w_in_cnt + c_FW'(i_tkeep[i]);
        end
    end

    assign w_app     = w_fire ? w_in_cnt : '0;
    assign w_in_data = w_fire ? (i_tdata & w_in_bmask) : '0;
    assign w_n       = (r_rem < c_DB32) ? r_rem[c_FW-1:0] : c_DB;
    assign w_skip_n  = (r_rem < 32'(r_fill)) ? r_rem[c_FW-1:0] : r_fill;

    always_comb begin
        w_state_n   = r_state;
        w_rem_n     = r_rem;
        w_cons      = '0;
        w_load      = 1'b0;
        w_load_n    = '0;
        w_load_last = 1'b0;
        w_frame_inc = 1'b0;
        w_trunc     = 1'b0;
        w_lenerr    = 1'b0;
        w_clean     = 1'b0;
        case (r_state)
            ST_HDR: begin
                if (r_fill >= c_FW'(4)) begin
                    w_cons  = c_FW'(4);
                    w_rem_n = w_hdr_len;
                    if (w_hdr_len == 32'd0) begin
                        w_frame_inc = 1'b1;
                    end else if (w_hdr_len > c_MAX) begin
                        w_lenerr  = 1'b1;
                        w_state_n = ST_SKIP;
                    end else begin
                        w_state_n = ST_PAYLOAD;
                    end
                end else if (r_eos) begin
                    // Segment over: any partial header left behind is dropped.
                    w_clean = 1'b1;
                    w_trunc = (r_fill != '0);
                    w_cons  = r_fill;
                end
            end
            ST_PAYLOAD: begin
                if (r_fill >= w_n) begin
                    if (w_out_free) begin
                        w_load      = 1'b1;
                        w_load_n    = w_n;
                        w_load_last = (r_rem == 32'(w_n));
                        w_cons      = w_n;
                        w_rem_n     = r_rem - 32'(w_n);
                        if (w_load_last) begin
                            w_frame_inc = 1'b1;
                            w_state_n   = ST_HDR;
                        end
                    end
                end else if (r_eos && w_out_free) begin
                    // Flush what remains of a cut-short frame as its last beat.
                    w_trunc     = 1'b1;
                    w_clean     = 1'b1;
                    w_load      = (r_fill != '0);
                    w_load_n    = r_fill;
                    w_load_last = 1'b1;
                    w_cons      = r_fill;
                    w_rem_n     = '0;
                    w_state_n   = ST_HDR;
                end
            end
            ST_SKIP: begin
                if (r_fill != '0 || r_rem == 32'd0) begin
                    w_cons  = w_skip_n;
                    w_rem_n = r_rem - 32'(w_skip_n);
                    if (w_rem_n == 32'd0) begin
                        w_state_n = ST_HDR;
                    end
                end else if (r_eos) begin
                    w_trunc   = 1'b1;
                    w_clean   = 1'b1;
                    w_rem_n   = '0;
                    w_state_n = ST_HDR;
                end
            end
            default: begin
                w_state_n = ST_HDR;
            end
        endcase
    end

    assign w_load_keep = {DATA_BYTES{1'b1}} >> (c_DB - w_load_n);
    assign w_ins_pos   = r_fill - w_cons;
    assign w_fill_n    = r_fill - w_cons + w_app;
    assign w_eos_n     = w_clean ? 1'b0 : (r_eos || (w_fire && i_tlast));

    // Bytes above the fill are always zero, so the shift-down and append merge with a plain OR.
    assign w_buf_n = (r_buf >> {w_cons, 3'b000})
                   | ({{c_OW{1'b0}}, w_in_data} << {w_ins_pos, 3'b000});

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_HDR;
            r_buf       <= '0;
            r_fill      <= '0;
            r_rem       <= '0;
            r_eos       <= 1'b0;
            r_rdy       <= 1'b0;
            o_tdata     <= '0;
            o_tkeep     <= '0;
            o_tlast     <= 1'b0;
            o_tvalid    <= 1'b0;
            o_frames    <= '0;
            o_err_trunc <= 1'b0;
            o_err_len   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_buf   <= w_buf_n;
            r_fill  <= w_fill_n;
            r_rem   <= w_rem_n;
            r_eos   <= w_eos_n;
            r_rdy   <= !w_eos_n && (w_fill_n <= c_DB);
            if (w_frame_inc) begin
                o_frames <= o_frames + 32'd1;
            end
            if (w_trunc) begin
                o_err_trunc <= 1'b1;
            end
            if (w_lenerr) begin
                o_err_len <= 1'b1;
            end
            if (w_load) begin
                o_tdata  <= r_buf[c_OW-1:0] & w_load_bmask;
                o_tkeep  <= w_load_keep;
                o_tlast  <= w_load_last;
                o_tvalid <= 1'b1;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
